// File: rtl/coin_pkg.sv
// Shared coin codes, FSM state encoding and denomination helpers for the
// arcade coin front end.
package coin_pkg;

  localparam int unsigned CODE_W = 3;
  localparam int unsigned AMT_W  = 16;

  localparam logic [CODE_W-1:0] COIN_NONE = 3'b000;
  localparam logic [CODE_W-1:0] COIN_5C   = 3'b001;
  localparam logic [CODE_W-1:0] COIN_10C  = 3'b010;
  localparam logic [CODE_W-1:0] COIN_25C  = 3'b011;
  localparam logic [CODE_W-1:0] COIN_1D   = 3'b100;
  localparam logic [CODE_W-1:0] COIN_2D   = 3'b101;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_VEND,
    S_DISP,
    S_GAME
  } state_t;

  // Value in cents of a coin code; invalid codes are worth nothing.
  function automatic logic [7:0] coin_value(input logic [CODE_W-1:0] code);
    logic [7:0] val;
    case (code)
      COIN_5C:  val = 8'd5;
      COIN_10C: val = 8'd10;
      COIN_25C: val = 8'd25;
      COIN_1D:  val = 8'd100;
      COIN_2D:  val = 8'd200;
      default:  val = 8'd0;
    endcase
    return val;
  endfunction

  // Largest denomination not exceeding the amount still owed.
  function automatic logic [CODE_W-1:0] greedy_coin(input logic [AMT_W-1:0] amount);
    logic [CODE_W-1:0] code;
    if (amount >= 16'd200)      code = COIN_2D;
    else if (amount >= 16'd100) code = COIN_1D;
    else if (amount >= 16'd25)  code = COIN_25C;
    else if (amount >= 16'd10)  code = COIN_10C;
    else if (amount >= 16'd5)   code = COIN_5C;
    else                        code = COIN_NONE;
    return code;
  endfunction

endpackage

// File: rtl/coin_timeout_timer.sv
// Inactivity timer: counts enabled cycles after a clear and raises a
// single-cycle expire flag when the count reaches TIMEOUT_CYC-1.
module coin_timeout_timer #(
  parameter int unsigned TIMEOUT_CYC = 6000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic expire
);

  localparam int unsigned CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             expire_q, expire_d;

  // Count saturates at the terminal value so the flag fires only once.
  always_comb begin
    cnt_d    = cnt_q;
    expire_d = 1'b0;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (cnt_q != CNT_W'(TIMEOUT_CYC - 1))) begin
      cnt_d    = cnt_q + CNT_W'(1);
      expire_d = (cnt_d == CNT_W'(TIMEOUT_CYC - 1));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      expire_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      expire_q <= expire_d;
    end
  end

  assign expire = expire_q;

endmodule

// File: rtl/coin_credit_ctrl.sv
// Multi-denomination coin acceptor: accumulates credit, starts the game at
// PRICE, and pays change or refunds one coin at a time to the dispenser.
module coin_credit_ctrl
  import coin_pkg::*;
#(
  parameter int unsigned CREDIT_W    = 10,
  parameter int unsigned PRICE       = 300,
  parameter logic [4:0]  ACCEPT_MASK = 5'b11111,
  parameter int unsigned MAX_COINS   = 8,
  parameter int unsigned TIMEOUT_CYC = 6000,
  localparam int unsigned COUNT_W    = $clog2(MAX_COINS + 1)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                coin_valid,
  input  logic [2:0]          coin_type,
  output logic                coin_ready,
  output logic                coin_accept,
  output logic                coin_reject,
  input  logic                return_req,
  output logic                game_start,
  output logic                in_game,
  input  logic                game_done,
  output logic                disp_valid,
  output logic [2:0]          disp_type,
  input  logic                disp_ready,
  output logic [CREDIT_W-1:0] credit,
  output logic [COUNT_W-1:0]  coin_count,
  output logic                timer_active
);

  // Mask indexed directly by coin code; codes 0, 6 and 7 are never accepted.
  localparam logic [7:0] CODE_MASK = {2'b00, ACCEPT_MASK, 1'b0};

  state_t              state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic [CREDIT_W-1:0] amount_q, amount_d;
  logic [COUNT_W-1:0]  count_q, count_d;
  logic [2:0]          code_q, code_d;
  logic                from_vend_q, from_vend_d;
  logic                exp_pend_q, exp_pend_d;
  logic                coin_ready_q, coin_ready_d;
  logic                coin_accept_q, coin_accept_d;
  logic                coin_reject_q, coin_reject_d;
  logic                game_start_q, game_start_d;
  logic                in_game_q, in_game_d;
  logic                disp_valid_q, disp_valid_d;
  logic [2:0]          disp_type_q, disp_type_d;
  logic                timer_active_q, timer_active_d;
  logic                tmr_clr;
  logic                tmr_expire;
  logic                coin_ok;

  coin_timeout_timer #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (timer_active_q),
    .clr    (tmr_clr),
    .expire (tmr_expire)
  );

  assign coin_ok = (coin_value(coin_type) != 8'd0) && CODE_MASK[coin_type]
                   && (count_q != COUNT_W'(MAX_COINS));

  // Next-state and registered-output logic.
  always_comb begin
    state_d       = state_q;
    credit_d      = credit_q;
    amount_d      = amount_q;
    count_d       = count_q;
    code_d        = code_q;
    from_vend_d   = from_vend_q;
    coin_accept_d = 1'b0;
    coin_reject_d = 1'b0;
    tmr_clr       = 1'b0;

    case (state_q)
      S_IDLE: begin
        // An expiry seen while in S_CHECK is remembered and honoured here.
        if ((return_req || tmr_expire || exp_pend_q) && (credit_q != '0)) begin
          amount_d    = credit_q;
          credit_d    = '0;
          from_vend_d = 1'b0;
          tmr_clr     = 1'b1;
          state_d     = S_DISP;
        end else if (coin_valid && coin_ready_q) begin
          code_d        = coin_type;
          coin_accept_d = coin_ok;
          coin_reject_d = !coin_ok;
          state_d       = S_CHECK;
        end
      end
      S_CHECK: begin
        state_d = S_IDLE;
        if (coin_accept_q) begin
          credit_d = credit_q + CREDIT_W'(coin_value(code_q));
          count_d  = count_q + COUNT_W'(1);
          if (count_q == '0) tmr_clr = 1'b1;
          if (credit_d >= CREDIT_W'(PRICE)) state_d = S_VEND;
        end
      end
      S_VEND: begin
        amount_d    = credit_q - CREDIT_W'(PRICE);
        credit_d    = '0;
        count_d     = '0;
        from_vend_d = 1'b1;
        tmr_clr     = 1'b1;
        state_d     = (amount_d != '0) ? S_DISP : S_GAME;
      end
      S_DISP: begin
        if (disp_valid_q && disp_ready) begin
          amount_d = amount_q - CREDIT_W'(coin_value(disp_type_q));
          if (amount_d == '0) begin
            count_d = '0;
            state_d = from_vend_q ? S_GAME : S_IDLE;
          end
        end
      end
      S_GAME: begin
        if (game_done) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    exp_pend_d     = (exp_pend_q | tmr_expire) & ~tmr_clr;
    coin_ready_d   = (state_d == S_IDLE);
    game_start_d   = (state_d == S_VEND);
    in_game_d      = (state_d == S_GAME);
    disp_valid_d   = (state_d == S_DISP);
    disp_type_d    = disp_valid_d ? greedy_coin(AMT_W'(amount_d)) : COIN_NONE;
    timer_active_d = ((state_d == S_IDLE) || (state_d == S_CHECK)) && (credit_d != '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      credit_q       <= '0;
      amount_q       <= '0;
      count_q        <= '0;
      code_q         <= '0;
      from_vend_q    <= 1'b0;
      exp_pend_q     <= 1'b0;
      coin_ready_q   <= 1'b1;
      coin_accept_q  <= 1'b0;
      coin_reject_q  <= 1'b0;
      game_start_q   <= 1'b0;
      in_game_q      <= 1'b0;
      disp_valid_q   <= 1'b0;
      disp_type_q    <= '0;
      timer_active_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      credit_q       <= credit_d;
      amount_q       <= amount_d;
      count_q        <= count_d;
      code_q         <= code_d;
      from_vend_q    <= from_vend_d;
      exp_pend_q     <= exp_pend_d;
      coin_ready_q   <= coin_ready_d;
      coin_accept_q  <= coin_accept_d;
      coin_reject_q  <= coin_reject_d;
      game_start_q   <= game_start_d;
      in_game_q      <= in_game_d;
      disp_valid_q   <= disp_valid_d;
      disp_type_q    <= disp_type_d;
      timer_active_q <= timer_active_d;
    end
  end

  assign coin_ready   = coin_ready_q;
  assign coin_accept  = coin_accept_q;
  assign coin_reject  = coin_reject_q;
  assign game_start   = game_start_q;
  assign in_game      = in_game_q;
  assign disp_valid   = disp_valid_q;
  assign disp_type    = disp_type_q;
  assign credit       = credit_q;
  assign coin_count   = count_q;
  assign timer_active = timer_active_q;

  // Credit and change arithmetic must never wrap.
  logic [CREDIT_W:0] add_wide;
  assign add_wide = {1'b0, credit_q} + (CREDIT_W + 1)'(coin_value(code_q));

  a_add_no_wrap: assert property (@(posedge clk) disable iff (!rst_n)
    (state_q == S_CHECK && coin_accept_q) |-> !add_wide[CREDIT_W]);
  a_vend_no_wrap: assert property (@(posedge clk) disable iff (!rst_n)
    (state_q == S_VEND) |-> (credit_q >= CREDIT_W'(PRICE)));
  a_disp_no_wrap: assert property (@(posedge clk) disable iff (!rst_n)
    (state_q == S_DISP && disp_valid_q && disp_ready)
      |-> (amount_q >= CREDIT_W'(coin_value(disp_type_q))));

endmodule

// File: tb/tb_coin_credit_ctrl.sv
// Scoreboard bench for coin_credit_ctrl: directed scenarios plus random coin
// and return traffic checked against a cents-level model of the vending rules.
module tb_coin_credit_ctrl;

  localparam int unsigned CREDIT_W    = 10;
  localparam int unsigned PRICE       = 300;
  localparam logic [4:0]  ACCEPT_MASK = 5'b11101;
  localparam int unsigned MAX_COINS   = 4;
  localparam int unsigned TIMEOUT_CYC = 40;
  localparam int unsigned COUNT_W     = $clog2(MAX_COINS + 1);

  logic                clk = 1'b0;
  logic                rst_n = 1'b1;
  logic                coin_valid = 1'b0;
  logic [2:0]          coin_type = 3'd0;
  logic                coin_ready, coin_accept, coin_reject;
  logic                return_req = 1'b0;
  logic                game_start, in_game;
  logic                game_done = 1'b0;
  logic                disp_valid;
  logic [2:0]          disp_type;
  logic                disp_ready = 1'b0;
  logic [CREDIT_W-1:0] credit;
  logic [COUNT_W-1:0]  coin_count;
  logic                timer_active;

  coin_credit_ctrl #(
    .CREDIT_W    (CREDIT_W),
    .PRICE       (PRICE),
    .ACCEPT_MASK (ACCEPT_MASK),
    .MAX_COINS   (MAX_COINS),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .coin_valid   (coin_valid),
    .coin_type    (coin_type),
    .coin_ready   (coin_ready),
    .coin_accept  (coin_accept),
    .coin_reject  (coin_reject),
    .return_req   (return_req),
    .game_start   (game_start),
    .in_game      (in_game),
    .game_done    (game_done),
    .disp_valid   (disp_valid),
    .disp_type    (disp_type),
    .disp_ready   (disp_ready),
    .credit       (credit),
    .coin_count   (coin_count),
    .timer_active (timer_active)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit acc;
    int credit;
  } coin_exp_t;

  coin_exp_t exp_coin[$];
  int        exp_disp[$];
  int        exp_games = 0;
  int        act_games = 0;
  int        m_credit  = 0;
  int        m_count   = 0;
  longint    t_first   = 0;
  longint    cyc       = 0;
  int        n_checks  = 0;
  int        n_fail    = 0;
  bit        hold_ready = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic bound_fail(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: wait bound expired (t=%0t)", name, $time);
  endtask

  function automatic int cents(input int code);
    case (code)
      1: return 5;
      2: return 10;
      3: return 25;
      4: return 100;
      5: return 200;
      default: return 0;
    endcase
  endfunction

  function automatic int code_for(input int c);
    case (c)
      5:   return 1;
      10:  return 2;
      25:  return 3;
      100: return 4;
      200: return 5;
      default: return 0;
    endcase
  endfunction

  function automatic bit takes(input int code, input int held);
    logic [4:0] m;
    m = ACCEPT_MASK;
    if (cents(code) == 0 || held >= int'(MAX_COINS)) return 1'b0;
    return m[code-1];
  endfunction

  // Change/refund is paid largest coin first, whatever the accept mask.
  task automatic push_change(input int amt);
    int denoms[5] = '{200, 100, 25, 10, 5};
    int left;
    left = amt;
    foreach (denoms[k])
      while (left >= denoms[k]) begin
        exp_disp.push_back(code_for(denoms[k]));
        left -= denoms[k];
      end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_coin_ready"},   32'(coin_ready),   32'd1);
    chk({tag, "_coin_accept"},  32'(coin_accept),  32'd0);
    chk({tag, "_coin_reject"},  32'(coin_reject),  32'd0);
    chk({tag, "_game_start"},   32'(game_start),   32'd0);
    chk({tag, "_in_game"},      32'(in_game),      32'd0);
    chk({tag, "_disp_valid"},   32'(disp_valid),   32'd0);
    chk({tag, "_disp_type"},    32'(disp_type),    32'd0);
    chk({tag, "_credit"},       32'(credit),       32'd0);
    chk({tag, "_coin_count"},   32'(coin_count),   32'd0);
    chk({tag, "_timer_active"}, 32'(timer_active), 32'd0);
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_credit"},     32'(credit),     32'(m_credit));
    chk({tag, "_coin_count"}, 32'(coin_count), 32'(m_count));
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (coin_ready !== 1'b1) begin
      if (n == 400) begin
        bound_fail("wait_coin_ready");
        return;
      end
      @(negedge clk);
      n++;
    end
  endtask

  task automatic finish_game();
    int n;
    n = 0;
    // return_req is poked while vending/dispensing; it must be ignored.
    while (in_game !== 1'b1 && n < 200) begin
      return_req = ($urandom_range(0, 3) == 0);
      @(negedge clk);
      n++;
    end
    return_req = 1'b0;
    if (in_game !== 1'b1) begin
      bound_fail("wait_in_game");
      return;
    end
    repeat ($urandom_range(1, 4)) @(negedge clk);
    chk("in_game_held", 32'(in_game), 32'd1);
    game_done = 1'b1;
    @(negedge clk);
    game_done = 1'b0;
  endtask

  task automatic do_coin(input int code);
    coin_exp_t e;
    bit        vend;
    wait_ready();
    check_idle("pre_coin");
    e.acc = takes(code, m_count);
    if (e.acc) begin
      if (m_count == 0) t_first = cyc;
      m_credit += cents(code);
      m_count++;
    end
    e.credit = m_credit;
    exp_coin.push_back(e);
    vend = (m_credit >= int'(PRICE));
    if (vend) begin
      exp_games++;
      push_change(m_credit - int'(PRICE));
      m_credit = 0;
      m_count  = 0;
    end
    coin_valid = 1'b1;
    coin_type  = 3'(code);
    @(negedge clk);
    coin_valid = 1'b0;
    coin_type  = 3'($urandom_range(0, 7));
    if (vend) finish_game();
  endtask

  task automatic do_return();
    wait_ready();
    if (m_credit > 0) push_change(m_credit);
    m_credit   = 0;
    m_count    = 0;
    return_req = 1'b1;
    @(negedge clk);
    return_req = 1'b0;
  endtask

  // Dispenser with random back-pressure.
  initial forever begin
    @(posedge clk);
    #1;
    disp_ready = !hold_ready && ($urandom_range(0, 2) != 0);
  end

  // Monitor: pops expectations whenever the DUT presents a response.
  bit         credit_pend = 1'b0;
  int         credit_pend_val = 0;
  bit         prev_stall = 1'b0;
  logic [2:0] prev_type = 3'd0;
  always @(negedge clk) begin
    coin_exp_t e;
    if (!rst_n) begin
      credit_pend = 1'b0;
      prev_stall  = 1'b0;
    end else begin
      if (credit_pend) begin
        chk("credit_after_coin", 32'(credit), 32'(credit_pend_val));
        credit_pend = 1'b0;
      end
      if (coin_accept || coin_reject) begin
        if (exp_coin.size() == 0) begin
          chk("unexpected_coin_resp", 32'(coin_accept | coin_reject), 32'd0);
        end else begin
          e = exp_coin.pop_front();
          chk("coin_accept", 32'(coin_accept), 32'(e.acc));
          chk("coin_reject", 32'(coin_reject), 32'(!e.acc));
          credit_pend     = 1'b1;
          credit_pend_val = e.credit;
        end
      end
      if (game_start) act_games++;
      if (in_game) chk("coin_ready_in_game", 32'(coin_ready), 32'd0);
      if (prev_stall) begin
        chk("stall_disp_valid", 32'(disp_valid), 32'd1);
        chk("stall_disp_type", 32'(disp_type), 32'(prev_type));
      end
      if (disp_valid && disp_ready) begin
        if (exp_disp.size() == 0) begin
          chk("unexpected_disp", 32'(disp_valid), 32'd0);
        end else begin
          chk("disp_type", 32'(disp_type), 32'(exp_disp.pop_front()));
          chk("credit_during_disp", 32'(credit), 32'd0);
        end
      end
      prev_stall = disp_valid && !disp_ready;
      prev_type  = disp_type;
    end
  end

  initial begin
    #500000;
    bound_fail("global_watchdog");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    longint h;
    int     n;
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("reset");
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    @(negedge clk);
    check_reset_outputs("post_reset");

    // Exact price, no change.
    do_coin(4); do_coin(4); do_coin(4);
    // Overpay by one dollar.
    do_coin(5); do_coin(5);
    // Fill to MAX_COINS, over-limit coin bounces, refund 25+10+5.
    do_coin(3); do_coin(1); do_coin(1); do_coin(1);
    do_coin(1);
    do_return();
    // Masked and invalid codes bounce; return with no credit is ignored.
    do_coin(2); do_coin(7); do_coin(0); do_coin(6);
    do_return();
    do_coin(4);
    do_return();

    for (int i = 0; i < 160; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      if (m_credit > 0 && (cyc - t_first) > longint'(TIMEOUT_CYC - 14)) do_return();
      else if ($urandom_range(0, 9) == 0) do_return();
      else do_coin($urandom_range(0, 7));
    end

    // Auto-refund on timeout; a coin offered in the expiry cycle is not taken.
    if (m_credit > 0) do_return();
    do_coin(4);
    h = cyc;
    while (cyc < h + longint'(TIMEOUT_CYC)) @(negedge clk);
    chk("timer_active_at_expiry", 32'(timer_active), 32'd1);
    chk("no_refund_before_expiry", 32'(disp_valid), 32'd0);
    coin_valid = 1'b1;
    coin_type  = 3'd4;
    push_change(m_credit);
    m_credit = 0;
    m_count  = 0;
    @(negedge clk);
    coin_valid = 1'b0;
    chk("refund_on_expiry", 32'(disp_valid), 32'd1);
    chk("credit_cleared_on_expiry", 32'(credit), 32'd0);

    // Reset in the middle of a stalled refund.
    wait_ready();
    hold_ready = 1'b1;
    do_coin(5);
    do_return();
    n = 0;
    while (disp_valid !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (disp_valid !== 1'b1) bound_fail("wait_disp_valid");
    repeat (3) @(negedge clk);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1 check_reset_outputs("mid_disp_reset");
    exp_disp.delete();
    m_credit = 0;
    m_count  = 0;
    @(posedge clk);
    #3 rst_n = 1'b1;
    hold_ready = 1'b0;
    @(negedge clk);
    check_reset_outputs("after_reset_release");
    do_coin(3);
    do_return();

    wait_ready();
    repeat (5) @(negedge clk);
    chk("coin_resp_left", 32'(exp_coin.size()), 32'd0);
    chk("disp_left", 32'(exp_disp.size()), 32'd0);
    chk("game_start_count", 32'(act_games), 32'(exp_games));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
